uart_config_negotiator: RTL and testbench
=========================================

Name: uart_config_negotiator

Overview:
- Runtime link-configuration engine placed between the UART receiver/RX FIFO and the transmitter.
- Watches the received byte stream for a run of SYN characters. On detection it enters configuration mode and parses configuration packets (id in bits [1:0], option in bits [3:2], bits [7:4] ignored).
- Acknowledges every packet over TX and commits the new data width, parity mode and stop bits atomically on END.
- Adds three things the plain package-level scheme lacks: a parametrised SYN count, an inactivity timeout, and ACK/NACK handshaking.

Parameters:
- SYN_NUMBER, 3, consecutive SYN (8'h16) bytes required to enter configuration mode (>=1).
- TIMEOUT_CYCLES, 1_000_000, idle clocks in configuration mode before abort (>=2).
- ACK_CHAR, 8'h06, byte sent for an accepted packet or entry.
- NACK_CHAR, 8'h15, byte sent for an illegal packet.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
- data_o  out  8  byte forwarded to RX FIFO
- data_valid_o  out  1  forward strobe
- tx_data_o  out  8  ACK/NACK byte
- tx_valid_o  out  1  request to transmit
- tx_ready_i  in  1  transmitter accepts tx_data_o when tx_valid_o && tx_ready_i
- config_o  out  6  committed uart_config_s {data_width, parity_mode, stop_bits}
- config_active_o  out  1  high while in configuration mode; TX arbiter grants TX to this block
- int_config_req_o  out  1  one-cycle pulse on entry to configuration mode
- int_config_fail_o  out  1  one-cycle pulse on illegal packet, timeout or overrun

Behaviour:
- Reset: config_o = STD_CONFIGURATION (8 bit, even, 1 stop); all other outputs 0; state IDLE; SYN counter 0; shadow = STD; pending register empty.
- IDLE:
  - Every rx byte is forwarded (data_o = rx_data_i, data_valid_o high the next cycle, 1-cycle latency), SYN bytes included.
  - A SYN byte increments the counter; any non-SYN byte clears it.
  - When the counter reaches SYN_NUMBER: clear it, copy config_o into shadow, pulse int_config_req_o, go to SEND with ACK_CHAR.
- SEND:
  - tx_valid_o held high with a stable tx_data_o until tx_ready_i.
  - On handshake: go to WAIT, or to IDLE if the sent byte completed END.
  - An rx byte arriving in SEND goes into a 1-entry pending register and is processed on entering WAIT (the same cycle the handshake completes).
  - A second byte while pending is full: pulse int_config_fail_o, discard shadow, go to IDLE once the current byte is sent.
- WAIT (config_active_o = 1, no forwarding). On each byte (or pending byte):
  - id DATA_WIDTH_ID: shadow.data_width = option; send ACK.
  - id PARITY_MODE_ID: shadow.parity_mode = option (DISABLED1/2 both legal); send ACK.
  - id STOP_BITS_ID: option SB_1BIT/SB_2BIT updates shadow and sends ACK. RESERVED1/2 leave shadow unchanged, pulse int_config_fail_o, send NACK, stay in configuration mode.
  - id END_CONFIGURATION_ID: config_o = shadow in the same cycle; send ACK; return to IDLE after the handshake.
- Timeout:
  - Counter is cleared on entry to configuration mode and on every rx byte, and counts in WAIT only.
  - When it reaches TIMEOUT_CYCLES-1: pulse int_config_fail_o, discard shadow (config_o unchanged), go to IDLE.
- config_active_o is high in SEND and WAIT, and low one cycle after the final ACK handshake.
- config_o changes only at END commit or reset.
- Reset mid-operation: immediate return to reset values; partial configuration lost.

Decomposition:
- UART_pkg additions: ACK/NACK character constants and a cfg_state_e enum (IDLE, SEND, WAIT).
- Reused from UART_pkg: uart_config_s, data_packet_u, SYN, the ID/option codes and STD_CONFIGURATION.
- One sub-module: uart_syn_detector (parametrised SYN run counter with match pulse output).

Test Plan:
- Bytes 16,16,16 in IDLE -> all three forwarded; int_config_req_o pulse; tx_data_o=06 until tx_ready_i; config_active_o=1.
- Enter mode, send 0x05 (data width 6 bit), 0x0B (parity disabled, 0b10_11? use id 10 option 10 = 0x0A), 0x07 (stop 2 bit), 0x00 -> four ACKs; config_o goes from 6'b11_00_00 to 6'b01_10_01 only in the END cycle.
- Enter mode, send 0x0B (stop RESERVED1) -> NACK 15, int_config_fail_o pulse, shadow unchanged; then 0x00 -> config_o stays at STD.
- Bytes 16,16,41,16 -> no entry; all four forwarded; counter cleared by 41.
- Enter mode, idle TIMEOUT_CYCLES (bench value 16) clocks -> int_config_fail_o at cycle 15, config_active_o drops, config_o unchanged; 0x41 is then forwarded.
- Hold tx_ready_i low during SEND and deliver two rx bytes -> first is pended; the second causes an int_config_fail_o pulse and a return to IDLE. Separately, assert rst_n_i mid-WAIT -> config_o returns to STD at once.

Source files
------------

// File: rtl/uart_config_negotiator_pkg.sv
// Shared UART link-configuration types: config word, packet layout, codes and negotiator state.
package uart_config_negotiator_pkg;

  localparam logic [7:0] SYN          = 8'h16;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NACK_DEFAULT = 8'h15;

  typedef enum logic [1:0] {DW_5BIT, DW_6BIT, DW_7BIT, DW_8BIT} data_width_e;
  typedef enum logic [1:0] {PM_EVEN, PM_ODD, PM_DISABLED1, PM_DISABLED2} parity_mode_e;
  typedef enum logic [1:0] {SB_1BIT, SB_2BIT, SB_RESERVED1, SB_RESERVED2} stop_bits_e;
  typedef enum logic [1:0] {
    END_CONFIGURATION_ID,
    DATA_WIDTH_ID,
    PARITY_MODE_ID,
    STOP_BITS_ID
  } packet_id_e;

  typedef struct packed {
    data_width_e  data_width;
    parity_mode_e parity_mode;
    stop_bits_e   stop_bits;
  } uart_config_s;

  // Only the low nibble of a configuration byte carries meaning.
  typedef struct packed {
    logic [1:0] option;
    packet_id_e id;
  } packet_code_s;

  typedef union packed {
    logic [7:0] raw;
    struct packed {
      logic [3:0]   reserved;
      packet_code_s code;
    } fields;
  } data_packet_u;

  localparam uart_config_s STD_CONFIGURATION = '{
    data_width:  DW_8BIT,
    parity_mode: PM_EVEN,
    stop_bits:   SB_1BIT
  };

  typedef enum logic [1:0] {IDLE, SEND, WAIT} cfg_state_e;

  typedef struct packed {
    uart_config_s cfg;
    logic         legal;
    logic         is_end;
  } packet_result_s;

  function automatic packet_result_s apply_packet(uart_config_s cur, packet_code_s code);
    packet_result_s res;
    res.cfg    = cur;
    res.legal  = 1'b1;
    res.is_end = 1'b0;
    case (code.id)
      DATA_WIDTH_ID:  res.cfg.data_width  = data_width_e'(code.option);
      PARITY_MODE_ID: res.cfg.parity_mode = parity_mode_e'(code.option);
      STOP_BITS_ID: begin
        if (stop_bits_e'(code.option) inside {SB_1BIT, SB_2BIT})
          res.cfg.stop_bits = stop_bits_e'(code.option);
        else
          res.legal = 1'b0;
      end
      END_CONFIGURATION_ID: res.is_end = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/uart_syn_detector.sv
// Counts consecutive SYN bytes; match fires combinationally on the byte completing the run.
module uart_syn_detector
  import uart_config_negotiator_pkg::*;
#(
  parameter int unsigned SYN_NUMBER = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       match
);

  localparam int unsigned CW = (SYN_NUMBER > 1) ? $clog2(SYN_NUMBER) : 1;

  logic [CW-1:0] count;
  logic          is_syn;
  logic          last;

  assign is_syn = (rx_data == SYN);
  assign last   = (count == CW'(SYN_NUMBER - 1));
  assign match  = enable && rx_valid && is_syn && last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (enable && rx_valid) begin
      if (!is_syn || last) count <= '0;
      else                 count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/uart_config_negotiator.sv
// Runtime UART link-configuration engine: SYN-run entry, packet parsing, ACK/NACK, atomic commit.
module uart_config_negotiator
  import uart_config_negotiator_pkg::*;
#(
  parameter int unsigned SYN_NUMBER     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  ACK_CHAR       = ACK_DEFAULT,
  parameter logic [7:0]  NACK_CHAR      = NACK_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic [5:0] config_o,
  output logic       config_active_o,
  output logic       int_config_req_o,
  output logic       int_config_fail_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  cfg_state_e     state_q, state_d;
  uart_config_s   shadow_q, shadow_d;
  uart_config_s   config_q, config_d;
  logic           pend_valid_q, pend_valid_d;
  packet_code_s   pend_code_q, pend_code_d;
  logic           abort_q, abort_d;
  logic           finish_q, finish_d;
  logic [7:0]     tx_data_q, tx_data_d;
  logic [TW-1:0]  timer_q, timer_d, timer_inc;
  logic [7:0]     fwd_data_q, fwd_data_d;
  logic           fwd_valid_q, fwd_valid_d;
  logic           req_q, req_d;
  logic           fail_q, fail_d;

  logic           syn_match;
  logic           tx_handshake;
  logic           process;
  packet_code_s   proc_code;
  packet_result_s result;

  uart_syn_detector #(.SYN_NUMBER(SYN_NUMBER)) u_syn_detector (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .enable   (state_q == IDLE),
    .rx_data  (rx_data_i),
    .rx_valid (rx_valid_i),
    .match    (syn_match)
  );

  assign tx_handshake = (state_q == SEND) && tx_ready_i;
  assign timer_inc    = timer_q + TW'(1);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    config_d     = config_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    abort_d      = abort_q;
    finish_d     = finish_q;
    tx_data_d    = tx_data_q;
    timer_d      = timer_q;
    req_d        = 1'b0;
    fail_d       = 1'b0;
    process      = 1'b0;
    proc_code    = rx_data_i[3:0];
    fwd_valid_d  = (state_q == IDLE) && rx_valid_i;
    fwd_data_d   = fwd_valid_d ? rx_data_i : fwd_data_q;

    case (state_q)
      IDLE: begin
        pend_valid_d = 1'b0;
        abort_d      = 1'b0;
        finish_d     = 1'b0;
        timer_d      = '0;
        if (syn_match) begin
          shadow_d  = config_q;
          req_d     = 1'b1;
          tx_data_d = ACK_CHAR;
          state_d   = SEND;
        end
      end
      SEND: begin
        timer_d = '0;
        if (tx_handshake) begin
          if (abort_q || finish_q) begin
            state_d      = IDLE;
            pend_valid_d = 1'b0;
          end else begin
            state_d = WAIT;
            // A pended byte is consumed on the handshake; a byte arriving now takes its slot.
            if (pend_valid_q) begin
              process      = 1'b1;
              proc_code    = pend_code_q;
              pend_valid_d = rx_valid_i;
              pend_code_d  = rx_data_i[3:0];
            end else if (rx_valid_i) begin
              process = 1'b1;
            end
          end
        end else if (rx_valid_i && !abort_q) begin
          if (pend_valid_q) begin
            fail_d       = 1'b1;
            abort_d      = 1'b1;
            pend_valid_d = 1'b0;
          end else begin
            pend_valid_d = 1'b1;
            pend_code_d  = rx_data_i[3:0];
          end
        end
      end
      WAIT: begin
        if (rx_valid_i) begin
          process = 1'b1;
        end else if (timer_inc == TW'(TIMEOUT_CYCLES - 1)) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    result = apply_packet(shadow_q, proc_code);
    if (process) begin
      shadow_d  = result.cfg;
      tx_data_d = result.legal ? ACK_CHAR : NACK_CHAR;
      fail_d    = !result.legal;
      finish_d  = result.is_end;
      timer_d   = '0;
      state_d   = SEND;
      if (result.is_end) config_d = result.cfg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      shadow_q     <= STD_CONFIGURATION;
      config_q     <= STD_CONFIGURATION;
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
      abort_q      <= 1'b0;
      finish_q     <= 1'b0;
      tx_data_q    <= '0;
      timer_q      <= '0;
      fwd_data_q   <= '0;
      fwd_valid_q  <= 1'b0;
      req_q        <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      config_q     <= config_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      abort_q      <= abort_d;
      finish_q     <= finish_d;
      tx_data_q    <= tx_data_d;
      timer_q      <= timer_d;
      fwd_data_q   <= fwd_data_d;
      fwd_valid_q  <= fwd_valid_d;
      req_q        <= req_d;
      fail_q       <= fail_d;
    end
  end

  assign data_o            = fwd_data_q;
  assign data_valid_o      = fwd_valid_q;
  assign tx_data_o         = tx_data_q;
  assign tx_valid_o        = (state_q == SEND);
  assign config_o          = config_q;
  assign config_active_o   = (state_q != IDLE);
  assign int_config_req_o  = req_q;
  assign int_config_fail_o = fail_q;

endmodule

// File: tb/tb_uart_config_negotiator.sv
// Scoreboard bench: forwarded bytes and TX responses are queued at stimulus time and popped on output.
module tb_uart_config_negotiator;
  import uart_config_negotiator_pkg::*;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam logic [7:0]  ACK        = 8'h06;
  localparam logic [7:0]  NACK       = 8'h15;
  localparam logic [5:0]  STD        = 6'b11_00_00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic [7:0] data_o, tx_data_o;
  logic       data_valid_o, tx_valid_o;
  logic [5:0] config_o;
  logic       config_active_o, int_config_req_o, int_config_fail_o;

  uart_config_negotiator #(
    .SYN_NUMBER     (3),
    .TIMEOUT_CYCLES (TB_TIMEOUT),
    .ACK_CHAR       (ACK),
    .NACK_CHAR      (NACK)
  ) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .rx_data_i         (rx_data),
    .rx_valid_i        (rx_valid),
    .data_o            (data_o),
    .data_valid_o      (data_valid_o),
    .tx_data_o         (tx_data_o),
    .tx_valid_o        (tx_valid_o),
    .tx_ready_i        (tx_ready),
    .config_o          (config_o),
    .config_active_o   (config_active_o),
    .int_config_req_o  (int_config_req_o),
    .int_config_fail_o (int_config_fail_o)
  );

  always #5 clk = ~clk;

  int         tests_run = 0;
  int         tests_failed = 0;
  int         req_seen = 0;
  int         fail_seen = 0;
  logic [7:0] fwd_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Outputs are sampled on the falling edge, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid_o) begin
        if (fwd_q.size() == 0) check("fwd_unexpected_queue_size", fwd_q.size(), 1);
        else                   check("fwd_data", data_o, fwd_q.pop_front());
      end
      if (tx_valid_o && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected_queue_size", tx_q.size(), 1);
        else                  check("tx_data", tx_data_o, tx_q.pop_front());
      end else if (tx_valid_o && tx_q.size() != 0) begin
        check("tx_hold", tx_data_o, tx_q[0]);
      end
      if (int_config_req_o)  req_seen++;
      if (int_config_fail_o) fail_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fwd);
    rx_data  = b;
    rx_valid = 1'b1;
    if (fwd) fwd_q.push_back(b);
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic enter_mode();
    send_byte(SYN, 1'b1);
    send_byte(SYN, 1'b1);
    tx_q.push_back(ACK);
    send_byte(SYN, 1'b1);
  endtask

  task automatic cfg_byte(input logic [7:0] b, input logic [7:0] resp);
    tx_q.push_back(resp);
    send_byte(b, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (config_active_o && n < 50) begin
      tick(1);
      n++;
    end
    check(tag, config_active_o, 1'b0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    fwd_q.delete();
    tx_q.delete();
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    int r0;
    int n;

    repeat (2) @(posedge clk);
    #1;
    check("rst_config", config_o, STD);
    check("rst_data_valid", data_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_tx_data", tx_data_o, 0);
    check("rst_active", config_active_o, 0);
    check("rst_req", int_config_req_o, 0);
    check("rst_fail", int_config_fail_o, 0);
    rst_n = 1'b1;
    tick(2);

    // Entry with the transmitter stalled: ACK must be held until ready.
    tx_ready = 1'b0;
    send_byte(SYN, 1'b1);
    send_byte(SYN, 1'b1);
    check("pre_entry_active", config_active_o, 0);
    tx_q.push_back(ACK);
    send_byte(SYN, 1'b1);
    check("entry_req", int_config_req_o, 1);
    check("entry_active", config_active_o, 1);
    check("entry_tx_valid", tx_valid_o, 1);
    check("entry_tx_data", tx_data_o, ACK);
    tick(3);
    check("ack_held", tx_valid_o, 1);
    check("req_one_cycle", int_config_req_o, 0);
    tx_ready = 1'b1;
    tick(1);
    check("wait_active", config_active_o, 1);
    check("wait_tx_idle", tx_valid_o, 0);

    // Full configuration: 6-bit, parity disabled, 2 stop bits, committed only on END.
    cfg_byte(8'h05, ACK); tick(3);
    cfg_byte(8'h0A, ACK); tick(3);
    cfg_byte(8'h07, ACK); tick(3);
    check("no_early_commit", config_o, STD);
    cfg_byte(8'h00, ACK);
    check("end_commit", config_o, 6'b01_10_01);
    wait_idle("end_idle");
    check("req_count_1", req_seen, 1);
    check("fail_count_0", fail_seen, 0);

    // Reserved stop-bit option: NACK, fail pulse, shadow untouched.
    do_reset();
    check("reset_restores_std", config_o, STD);
    enter_mode();
    tick(2);
    f0 = fail_seen;
    cfg_byte(8'h0B, NACK);
    check("nack_fail_pulse", int_config_fail_o, 1);
    tick(3);
    check("nack_stays_active", config_active_o, 1);
    cfg_byte(8'h00, ACK);
    check("nack_config_std", config_o, STD);
    wait_idle("nack_idle");
    check("nack_fail_count", fail_seen, f0 + 1);

    // A non-SYN byte breaks the run; the counter restarts.
    r0 = req_seen;
    send_byte(SYN, 1'b1);
    send_byte(SYN, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(SYN, 1'b1);
    tick(1);
    check("broken_run_inactive", config_active_o, 0);
    check("broken_run_no_req", req_seen, r0);
    send_byte(SYN, 1'b1);
    check("second_syn_inactive", config_active_o, 0);
    tx_q.push_back(ACK);
    send_byte(SYN, 1'b1);
    check("third_syn_active", config_active_o, 1);

    // Timeout: one ACK cycle plus TIMEOUT_CYCLES-1 idle WAIT cycles.
    f0 = fail_seen;
    n = 0;
    while (!int_config_fail_o && n < 100) begin
      tick(1);
      n++;
    end
    check("timeout_latency", n, TB_TIMEOUT);
    check("timeout_inactive", config_active_o, 0);
    check("timeout_config", config_o, STD);
    send_byte(8'h41, 1'b1);
    tick(1);
    check("timeout_fail_count", fail_seen, f0 + 1);

    // A byte arriving during a stalled ACK is pended and handled on the handshake.
    tx_ready = 1'b0;
    enter_mode();
    cfg_byte(8'h05, ACK);
    tick(2);
    check("pend_hold_data", tx_data_o, ACK);
    tx_ready = 1'b1;
    tick(1);
    check("pend_processed", tx_valid_o, 1);
    tick(1);
    check("pend_back_to_wait", config_active_o, 1);
    cfg_byte(8'h00, ACK);
    check("pend_commit", config_o, 6'b01_00_00);
    wait_idle("pend_idle");

    // Second byte while the pending slot is full: overrun aborts.
    tx_ready = 1'b0;
    enter_mode();
    send_byte(8'h07, 1'b0);
    f0 = fail_seen;
    send_byte(8'h0A, 1'b0);
    check("overrun_fail_pulse", int_config_fail_o, 1);
    tick(2);
    check("overrun_still_sending", config_active_o, 1);
    tx_ready = 1'b1;
    tick(1);
    check("overrun_idle", config_active_o, 0);
    tick(3);
    check("overrun_fail_count", fail_seen, f0 + 1);
    check("overrun_config", config_o, 6'b01_00_00);

    // Reset in the middle of WAIT drops everything immediately.
    enter_mode();
    tick(2);
    cfg_byte(8'h0A, ACK);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_config", config_o, STD);
    check("async_rst_active", config_active_o, 0);
    check("async_rst_tx_valid", tx_valid_o, 0);
    fwd_q.delete();
    tx_q.delete();
    tick(1);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'h41, 1'b1);
    tick(2);
    check("post_rst_config", config_o, STD);

    check("fwd_q_drained", fwd_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
